// File: rtl/doc_safety_cc_payload_gen.sv
// rtl/doc_safety_cc_payload_gen.sv - folds safety samples into a CRC-32 payload for cross-comparison
module doc_safety_cc_payload_gen #(
    parameter int SAMPLES_PER_PAYLOAD  = 8,
    parameter int STALL_TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        gen_start,
    input  logic        gen_abort,
    input  logic        sample_valid,
    input  logic [31:0] sample_data,
    output logic        payload_valid,
    input  logic        payload_ack,
    output logic [31:0] payload_data,
    output logic [7:0]  payload_seq,
    output logic        busy,
    output logic        stall_err,
    output logic        start_ignored
);

    localparam logic [31:0] CRC_POLY   = 32'h04C11DB7;
    localparam logic [31:0] CRC_INIT   = 32'hFFFFFFFF;
    localparam logic [7:0]  LAST_IDX   = 8'(SAMPLES_PER_PAYLOAD - 1);
    localparam logic [15:0] STALL_LAST = 16'(STALL_TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_crc;
    logic [7:0]  r_sample_cnt;
    logic [15:0] r_stall_cnt;
    logic        r_payload_valid;
    logic [31:0] r_payload_data;
    logic [7:0]  r_payload_seq;
    logic        r_stall_err;
    logic        r_start_ignored;

    logic        w_start_go;
    logic        w_accept;
    logic        w_complete;
    logic        w_timeout;
    logic        w_ack_go;
    logic        w_start_ign;
    logic [31:0] w_crc_nxt;

    // Whole 32-bit word per cycle, MSB first, no reflection and no final XOR.
    function automatic logic [31:0] f_crc32(input logic [31:0] crc, input logic [31:0] data);
        logic [31:0] c;
        logic        fb;
        c = crc;
        for (int i = 31; i >= 0; i--) begin
            fb = c[31] ^ data[i];
            c  = {c[30:0], 1'b0};
            if (fb) begin
                c = c ^ CRC_POLY;
            end
        end
        return c;
    endfunction

    assign w_crc_nxt = f_crc32(r_crc, sample_data);

    always_comb begin
        w_state_nxt = r_state;
        w_start_go  = 1'b0;
        w_accept    = 1'b0;
        w_complete  = 1'b0;
        w_timeout   = 1'b0;
        w_ack_go    = 1'b0;
        w_start_ign = 1'b0;
        if (gen_abort) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (gen_start) begin
                        w_start_go  = 1'b1;
                        w_state_nxt = COLLECT;
                    end
                end
                COLLECT: begin
                    w_start_ign = gen_start;
                    // A sample arriving on the timeout cycle wins: it completes or restarts the stall count.
                    if (sample_valid) begin
                        w_accept = 1'b1;
                        if (r_sample_cnt == LAST_IDX) begin
                            w_complete  = 1'b1;
                            w_state_nxt = HOLD;
                        end
                    end else if (r_stall_cnt == STALL_LAST) begin
                        w_timeout   = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end
                HOLD: begin
                    w_start_ign = gen_start;
                    if (payload_ack) begin
                        w_ack_go    = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= IDLE;
            r_crc           <= 32'h0;
            r_sample_cnt    <= 8'h0;
            r_stall_cnt     <= 16'h0;
            r_payload_valid <= 1'b0;
            r_payload_data  <= 32'h0;
            r_payload_seq   <= 8'h0;
            r_stall_err     <= 1'b0;
            r_start_ignored <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_stall_err <= w_timeout;
            if (w_start_ign) begin
                r_start_ignored <= 1'b1;
            end
            if (w_start_go) begin
                r_crc        <= CRC_INIT;
                r_sample_cnt <= 8'h0;
                r_stall_cnt  <= 16'h0;
            end else if (w_accept) begin
                r_crc        <= w_crc_nxt;
                r_sample_cnt <= r_sample_cnt + 8'h1;
                r_stall_cnt  <= 16'h0;
            end else if (r_state == COLLECT && !w_timeout && !gen_abort) begin
                r_stall_cnt <= r_stall_cnt + 16'h1;
            end
            if (w_complete) begin
                r_payload_data  <= w_crc_nxt;
                r_payload_valid <= 1'b1;
            end
            if (w_ack_go) begin
                r_payload_valid <= 1'b0;
                r_payload_seq   <= r_payload_seq + 8'h1;
            end
            if (gen_abort) begin
                r_payload_valid <= 1'b0;
            end
        end
    end

    assign payload_valid = r_payload_valid;
    assign payload_data  = r_payload_data;
    assign payload_seq   = r_payload_seq;
    assign busy          = (r_state != IDLE);
    assign stall_err     = r_stall_err;
    assign start_ignored = r_start_ignored;

endmodule

// File: tb/tb_doc_safety_cc_payload_gen.sv
// tb/tb_doc_safety_cc_payload_gen.sv - directed self-checking bench for doc_safety_cc_payload_gen
module tb_doc_safety_cc_payload_gen;

    localparam logic [31:0] POLY = 32'h04C11DB7;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic        a_start, a_abort, a_svalid, a_ack;
    logic [31:0] a_sdata;
    logic        a_valid, a_busy, a_stall, a_ign;
    logic [31:0] a_data;
    logic [7:0]  a_seq;

    logic        b_start, b_abort, b_svalid, b_ack;
    logic [31:0] b_sdata;
    logic        b_valid, b_busy, b_stall, b_ign;
    logic [31:0] b_data;
    logic [7:0]  b_seq;

    doc_safety_cc_payload_gen #(.SAMPLES_PER_PAYLOAD(8), .STALL_TIMEOUT_CYCLES(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .gen_start(a_start), .gen_abort(a_abort),
        .sample_valid(a_svalid), .sample_data(a_sdata), .payload_valid(a_valid),
        .payload_ack(a_ack), .payload_data(a_data), .payload_seq(a_seq),
        .busy(a_busy), .stall_err(a_stall), .start_ignored(a_ign)
    );

    doc_safety_cc_payload_gen #(.SAMPLES_PER_PAYLOAD(1), .STALL_TIMEOUT_CYCLES(1024)) dut_b (
        .clk(clk), .rst_n(rst_n), .gen_start(b_start), .gen_abort(b_abort),
        .sample_valid(b_svalid), .sample_data(b_sdata), .payload_valid(b_valid),
        .payload_ack(b_ack), .payload_data(b_data), .payload_seq(b_seq),
        .busy(b_busy), .stall_err(b_stall), .start_ignored(b_ign)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_crc;
    logic [7:0]  exp_seq_b;
    logic [31:0] d;
    logic [31:0] vec [8] = '{32'h00000001, 32'h80000000, 32'hDEADBEEF, 32'hCAFEF00D,
                             32'h00000000, 32'hFFFFFFFF, 32'h13579BDF, 32'h2468ACE0};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] crc_model(input logic [31:0] crc, input logic [31:0] data);
        logic [31:0] x;
        x = crc ^ data;
        for (int k = 0; k < 32; k++) begin
            x = x[31] ? ((x << 1) ^ POLY) : (x << 1);
        end
        return x;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic a_start_pulse();
        a_start = 1'b1;
        step();
        a_start = 1'b0;
        exp_crc = 32'hFFFFFFFF;
    endtask

    task automatic a_sample(input logic [31:0] v);
        a_svalid = 1'b1;
        a_sdata  = v;
        step();
        a_svalid = 1'b0;
        exp_crc  = crc_model(exp_crc, v);
    endtask

    task automatic a_ack_pulse();
        a_ack = 1'b1;
        step();
        a_ack = 1'b0;
    endtask

    task automatic check_reset_a(input string tag);
        check({tag, "_valid"}, 32'(a_valid), 32'd0);
        check({tag, "_data"},  a_data,       32'd0);
        check({tag, "_seq"},   32'(a_seq),   32'd0);
        check({tag, "_busy"},  32'(a_busy),  32'd0);
        check({tag, "_stall"}, 32'(a_stall), 32'd0);
        check({tag, "_ign"},   32'(a_ign),   32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        {a_start, a_abort, a_svalid, a_ack} = 4'b0;
        {b_start, b_abort, b_svalid, b_ack} = 4'b0;
        a_sdata = 32'h0;
        b_sdata = 32'h0;
        exp_crc = 32'hFFFFFFFF;
        step();
        step();
        check_reset_a("rst_a");
        check("rst_b_valid", 32'(b_valid), 32'd0);
        check("rst_b_busy",  32'(b_busy),  32'd0);
        rst_n = 1'b1;
        step();

        // samples and acks while idle are dropped
        a_svalid = 1'b1; a_sdata = 32'hDEADBEEF; a_ack = 1'b1;
        step();
        a_svalid = 1'b0; a_ack = 1'b0;
        check("idle_busy",  32'(a_busy),  32'd0);
        check("idle_valid", 32'(a_valid), 32'd0);
        check("idle_seq",   32'(a_seq),   32'd0);

        // eight samples with idle gaps
        a_start_pulse();
        check("collect_busy", 32'(a_busy), 32'd1);
        for (int i = 0; i < 8; i++) begin
            a_sample(vec[i]);
            if (i < 7) check("valid_early", 32'(a_valid), 32'd0);
            if (i % 2 == 1 && i < 7) step();
        end
        check("p1_valid", 32'(a_valid), 32'd1);
        check("p1_data",  a_data,       exp_crc);
        check("p1_seq",   32'(a_seq),   32'd0);

        // HOLD stays stable; sample dropped, start flagged as ignored
        a_svalid = 1'b1; a_sdata = 32'h12345678; a_start = 1'b1;
        step();
        a_svalid = 1'b0; a_start = 1'b0;
        step();
        check("hold_valid", 32'(a_valid), 32'd1);
        check("hold_data",  a_data,       exp_crc);
        check("hold_seq",   32'(a_seq),   32'd0);
        check("hold_ign",   32'(a_ign),   32'd1);
        check("hold_busy",  32'(a_busy),  32'd1);
        a_ack_pulse();
        check("ack_valid", 32'(a_valid), 32'd0);
        check("ack_seq",   32'(a_seq),   32'd1);
        check("ack_busy",  32'(a_busy),  32'd0);

        // back-to-back samples, different data
        a_start_pulse();
        for (int i = 0; i < 8; i++) a_sample(~vec[i] ^ 32'(i));
        check("p2_data", a_data,       exp_crc);
        check("p2_seq",  32'(a_seq),   32'd1);
        a_ack_pulse();
        check("p2_seq_inc", 32'(a_seq), 32'd2);

        // stall timeout with STALL_TIMEOUT_CYCLES=4
        a_start_pulse();
        a_sample(32'hA5A5A5A5);
        step(); step(); step();
        check("stall_pre",      32'(a_stall), 32'd0);
        check("stall_pre_busy", 32'(a_busy),  32'd1);
        step();
        check("stall_pulse", 32'(a_stall), 32'd1);
        check("stall_busy",  32'(a_busy),  32'd0);
        check("stall_valid", 32'(a_valid), 32'd0);
        check("stall_seq",   32'(a_seq),   32'd2);
        step();
        check("stall_once", 32'(a_stall), 32'd0);

        // abort + ack + final sample in one cycle: abort wins
        a_start_pulse();
        for (int i = 0; i < 7; i++) a_sample(vec[i]);
        a_abort = 1'b1; a_ack = 1'b1; a_svalid = 1'b1; a_sdata = vec[7];
        step();
        a_abort = 1'b0; a_ack = 1'b0; a_svalid = 1'b0;
        check("abort_valid", 32'(a_valid), 32'd0);
        check("abort_busy",  32'(a_busy),  32'd0);
        check("abort_seq",   32'(a_seq),   32'd2);
        step();
        check("abort_valid_later", 32'(a_valid), 32'd0);
        check("abort_no_stall",    32'(a_stall), 32'd0);

        // asynchronous reset mid-COLLECT
        a_start_pulse();
        for (int i = 0; i < 3; i++) a_sample(vec[i]);
        rst_n = 1'b0;
        #2;
        check_reset_a("midrst");
        step();
        rst_n = 1'b1;
        a_svalid = 1'b1; a_sdata = 32'h0BADF00D;
        for (int i = 0; i < 10; i++) step();
        a_svalid = 1'b0;
        check("post_rst_valid", 32'(a_valid), 32'd0);
        check("post_rst_busy",  32'(a_busy),  32'd0);
        check("post_rst_stall", 32'(a_stall), 32'd0);

        // start and abort together in IDLE
        a_start = 1'b1; a_abort = 1'b1;
        step();
        a_start = 1'b0; a_abort = 1'b0;
        check("sa_busy", 32'(a_busy), 32'd0);
        check("sa_ign",  32'(a_ign),  32'd0);

        // fresh payload after reset starts from a clean CRC
        a_start_pulse();
        for (int i = 0; i < 8; i++) a_sample(vec[i]);
        check("p3_data",  a_data,       exp_crc);
        check("p3_seq",   32'(a_seq),   32'd0);
        a_ack_pulse();

        // single-sample payloads
        b_start = 1'b1; step(); b_start = 1'b0;
        b_svalid = 1'b1; b_sdata = 32'hFFFFFFFF; step(); b_svalid = 1'b0;
        check("single_valid", 32'(b_valid), 32'd1);
        check("single_data",  b_data,       32'h00000000);
        check("single_seq",   32'(b_seq),   32'd0);
        b_ack = 1'b1; step(); b_ack = 1'b0;
        check("single_seq_inc", 32'(b_seq), 32'd1);

        // 256 complete cycles wrap the sequence number
        exp_seq_b = 8'd1;
        for (int k = 0; k < 256; k++) begin
            d = 32'(k) * 32'h9E3779B9;
            b_start = 1'b1; step(); b_start = 1'b0;
            b_svalid = 1'b1; b_sdata = d; step(); b_svalid = 1'b0;
            check("wrap_seq",  32'(b_seq), 32'(exp_seq_b));
            check("wrap_data", b_data,     crc_model(32'hFFFFFFFF, d));
            b_ack = 1'b1; step(); b_ack = 1'b0;
            exp_seq_b = exp_seq_b + 8'd1;
            check("wrap_seq_ack", 32'(b_seq), 32'(exp_seq_b));
        end
        check("wrap_final", 32'(b_seq), 32'd1);
        check("b_no_stall", 32'(b_stall), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
